key_line_buffer: RTL and testbench

Parametrised keyboard line editor that follows the scan-code decoder stage. It converts each new PS/2 key press (9-bit code, bit 8 = E0 prefix) into a 6-bit character code and stores it in a DEPTH-entry line buffer. The buffer supports backspace editing and, on Enter, streams the committed line out through a valid/ready handshake. It sits between the keyboard receiver and the game/display logic.

---
 rtl/key_pkg.sv | 30 +++
 rtl/key_code_decoder.sv | 72 +++++++
 rtl/key_line_buffer.sv | 121 ++++++++++++
 tb/tb_key_line_buffer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants, types and helpers for the keyboard line editor.
package key_pkg;

  localparam int CODE_W = 6;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_NONE    = 6'd0;
  localparam code_t CODE_SPACE   = 6'd27;
  localparam code_t CODE_DIGIT0  = 6'd28;
  localparam code_t CODE_INVALID = 6'd63;

  localparam logic [8:0] SC_BKSP  = 9'h066;
  localparam logic [8:0] SC_ENTER = 9'h05A;

  typedef enum logic {
    ST_EDIT    = 1'b0,
    ST_READOUT = 1'b1
  } line_state_t;

  // Digit n maps to CODE_DIGIT0+n when digits are enabled, otherwise invalid.
  function automatic code_t digit_code(input logic en, input logic [3:0] n);
    if (en) begin
      return CODE_DIGIT0 + {2'b00, n};
    end else begin
      return CODE_INVALID;
    end
  endfunction

endpackage

// File: rtl/key_code_decoder.sv
// Combinational scan-code to character-code translation with command flags.
module key_code_decoder
  import key_pkg::*;
#(
  parameter bit DIGITS_EN = 1'b1
) (
  input  logic [8:0] last_change,
  output code_t      code,
  output logic       is_char,
  output logic       is_bksp,
  output logic       is_enter
);

  code_t code_s;
  logic  bksp_s;
  logic  enter_s;

  // Map a scan code to its character code; E0-prefixed codes fall to default.
  always_comb begin
    code_s  = CODE_INVALID;
    bksp_s  = 1'b0;
    enter_s = 1'b0;
    case (last_change)
      9'h01C: code_s = 6'd1;
      9'h032: code_s = 6'd2;
      9'h021: code_s = 6'd3;
      9'h023: code_s = 6'd4;
      9'h024: code_s = 6'd5;
      9'h02B: code_s = 6'd6;
      9'h034: code_s = 6'd7;
      9'h033: code_s = 6'd8;
      9'h043: code_s = 6'd9;
      9'h03B: code_s = 6'd10;
      9'h042: code_s = 6'd11;
      9'h04B: code_s = 6'd12;
      9'h03A: code_s = 6'd13;
      9'h031: code_s = 6'd14;
      9'h044: code_s = 6'd15;
      9'h04D: code_s = 6'd16;
      9'h015: code_s = 6'd17;
      9'h02D: code_s = 6'd18;
      9'h01B: code_s = 6'd19;
      9'h02C: code_s = 6'd20;
      9'h03C: code_s = 6'd21;
      9'h02A: code_s = 6'd22;
      9'h01D: code_s = 6'd23;
      9'h022: code_s = 6'd24;
      9'h035: code_s = 6'd25;
      9'h01A: code_s = 6'd26;
      9'h029: code_s = CODE_SPACE;
      9'h045: code_s = digit_code(DIGITS_EN, 4'd0);
      9'h016: code_s = digit_code(DIGITS_EN, 4'd1);
      9'h01E: code_s = digit_code(DIGITS_EN, 4'd2);
      9'h026: code_s = digit_code(DIGITS_EN, 4'd3);
      9'h025: code_s = digit_code(DIGITS_EN, 4'd4);
      9'h02E: code_s = digit_code(DIGITS_EN, 4'd5);
      9'h036: code_s = digit_code(DIGITS_EN, 4'd6);
      9'h03D: code_s = digit_code(DIGITS_EN, 4'd7);
      9'h03E: code_s = digit_code(DIGITS_EN, 4'd8);
      9'h046: code_s = digit_code(DIGITS_EN, 4'd9);
      SC_BKSP:  bksp_s  = 1'b1;
      SC_ENTER: enter_s = 1'b1;
      default:  code_s  = CODE_INVALID;
    endcase
  end

  assign code     = code_s;
  assign is_char  = (code_s != CODE_INVALID);
  assign is_bksp  = bksp_s;
  assign is_enter = enter_s;

endmodule

// File: rtl/key_line_buffer.sv
// Line editor: stores decoded characters, supports backspace, streams the
// committed line out over valid/ready when Enter is pressed.
module key_line_buffer
  import key_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit DIGITS_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_valid,
  input  logic [8:0]                 last_change,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CODE_W-1:0]          out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CODE_W-1:0]          last_char,
  output logic                       busy,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  line_state_t   state_r;
  code_t         buf_r [DEPTH];
  logic [CW-1:0] count_r;
  logic [AW-1:0] rd_ptr_r;
  code_t         last_char_r;
  logic          overflow_r;

  code_t         code_s;
  logic          is_char_s;
  logic          is_bksp_s;
  logic          is_enter_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] bk_idx_s;
  logic [AW-1:0] last_idx_s;

  key_code_decoder #(
    .DIGITS_EN (DIGITS_EN)
  ) u_decoder (
    .last_change (last_change),
    .code        (code_s),
    .is_char     (is_char_s),
    .is_bksp     (is_bksp_s),
    .is_enter    (is_enter_s)
  );

  // Index arithmetic is only used when the guarding count condition holds,
  // so truncation to the array index width never loses information.
  assign wr_idx_s   = AW'(count_r);
  assign bk_idx_s   = AW'(count_r - CW'(2));
  assign last_idx_s = AW'(count_r - CW'(1));

  // Editing / readout state machine and line storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EDIT;
      count_r     <= '0;
      rd_ptr_r    <= '0;
      last_char_r <= CODE_NONE;
      overflow_r  <= 1'b0;
    end else begin
      overflow_r <= 1'b0;
      case (state_r)
        ST_EDIT: begin
          if (key_valid && is_char_s) begin
            if (count_r < DEPTH_C) begin
              buf_r[wr_idx_s] <= code_s;
              count_r         <= count_r + CW'(1);
              last_char_r     <= code_s;
            end else begin
              overflow_r <= 1'b1;
            end
          end else if (key_valid && is_bksp_s) begin
            if (count_r != '0) begin
              count_r     <= count_r - CW'(1);
              last_char_r <= (count_r > CW'(1)) ? buf_r[bk_idx_s] : CODE_NONE;
            end
          end else if (key_valid && is_enter_s && (count_r != '0)) begin
            state_r  <= ST_READOUT;
            rd_ptr_r <= '0;
          end
        end
        ST_READOUT: begin
          // Characters arriving while the line drains are dropped.
          if (key_valid && is_char_s) begin
            overflow_r <= 1'b1;
          end
          if (out_ready) begin
            if (rd_ptr_r == last_idx_s) begin
              state_r     <= ST_EDIT;
              count_r     <= '0;
              rd_ptr_r    <= '0;
              last_char_r <= CODE_NONE;
            end else begin
              rd_ptr_r <= rd_ptr_r + AW'(1);
            end
          end
        end
        default: begin
          state_r  <= ST_EDIT;
          count_r  <= '0;
          rd_ptr_r <= '0;
        end
      endcase
    end
  end

  assign busy      = (state_r == ST_READOUT);
  assign out_valid = busy;
  assign out_data  = busy ? buf_r[rd_ptr_r] : CODE_NONE;
  assign out_last  = busy && (rd_ptr_r == last_idx_s);
  assign count     = count_r;
  assign last_char = last_char_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_key_line_buffer.sv
// Bench: two configurations (16 deep with digits, 4 deep without digits)
// share one stimulus stream and are compared every cycle against a
// line-level reference model.
module tb_key_line_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [8:0] last_change = 9'h000;
  logic       out_ready = 1'b0;

  logic       ov0, ol0, bz0, of0;
  logic [5:0] od0, lc0;
  logic [4:0] cn0;
  logic       ov1, ol1, bz1, of1;
  logic [5:0] od1, lc1;
  logic [2:0] cn1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_line_buffer #(.DEPTH(16), .DIGITS_EN(1'b1)) u_big (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0),
    .count(cn0), .last_char(lc0), .busy(bz0), .overflow(of0));

  key_line_buffer #(.DEPTH(4), .DIGITS_EN(1'b0)) u_small (
    .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1),
    .count(cn1), .last_char(lc1), .busy(bz1), .overflow(of1));

  // Reference model ------------------------------------------------------
  localparam int K_INVALID = 63;
  localparam int K_BKSP    = 100;
  localparam int K_ENTER   = 101;

  int sc_let[26] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34, 'h33, 'h43,
                     'h3B, 'h42, 'h4B, 'h3A, 'h31, 'h44, 'h4D, 'h15, 'h2D,
                     'h1B, 'h2C, 'h3C, 'h2A, 'h1D, 'h22, 'h35, 'h1A};
  int sc_dig[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};

  int mdepth[2] = '{16, 4};
  bit mdig[2]   = '{1'b1, 1'b0};
  int mbuf[2][64];
  int msize[2];
  int mrd[2];
  int mlast[2];
  bit mbusy[2];
  bit movf[2];

  function automatic int decode(int lc, bit dig);
    if (lc == 'h66) return K_BKSP;
    if (lc == 'h5A) return K_ENTER;
    if (lc == 'h29) return 27;
    for (int i = 0; i < 26; i++) if (lc == sc_let[i]) return i + 1;
    for (int i = 0; i < 10; i++) if (lc == sc_dig[i]) return dig ? 28 + i : K_INVALID;
    return K_INVALID;
  endfunction

  task automatic model_step(int i, bit kv, int lc, bit rdy, bit r);
    int c;
    movf[i] = 1'b0;
    if (r) begin
      mbusy[i] = 1'b0; msize[i] = 0; mrd[i] = 0; mlast[i] = 0;
      return;
    end
    c = decode(lc, mdig[i]);
    if (!mbusy[i]) begin
      if (kv && c >= 1 && c <= 37) begin
        if (msize[i] < mdepth[i]) begin
          mbuf[i][msize[i]] = c;
          msize[i]++;
          mlast[i] = c;
        end else begin
          movf[i] = 1'b1;
        end
      end else if (kv && c == K_BKSP && msize[i] > 0) begin
        msize[i]--;
        mlast[i] = (msize[i] > 0) ? mbuf[i][msize[i] - 1] : 0;
      end else if (kv && c == K_ENTER && msize[i] > 0) begin
        mbusy[i] = 1'b1;
        mrd[i]   = 0;
      end
    end else begin
      if (kv && c >= 1 && c <= 37) movf[i] = 1'b1;
      if (rdy) begin
        if (mrd[i] == msize[i] - 1) begin
          mbusy[i] = 1'b0; msize[i] = 0; mrd[i] = 0; mlast[i] = 0;
        end else begin
          mrd[i]++;
        end
      end
    end
  endtask

  // Checking helpers -----------------------------------------------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("big.out_valid", 32'(ov0), 32'(mbusy[0]));
    chk("big.busy",      32'(bz0), 32'(mbusy[0]));
    chk("big.out_data",  32'(od0), mbusy[0] ? mbuf[0][mrd[0]] : 0);
    chk("big.out_last",  32'(ol0), 32'(mbusy[0] && (mrd[0] == msize[0] - 1)));
    chk("big.count",     32'(cn0), msize[0]);
    chk("big.last_char", 32'(lc0), mlast[0]);
    chk("big.overflow",  32'(of0), 32'(movf[0]));
    chk("small.out_valid", 32'(ov1), 32'(mbusy[1]));
    chk("small.busy",      32'(bz1), 32'(mbusy[1]));
    chk("small.out_data",  32'(od1), mbusy[1] ? mbuf[1][mrd[1]] : 0);
    chk("small.out_last",  32'(ol1), 32'(mbusy[1] && (mrd[1] == msize[1] - 1)));
    chk("small.count",     32'(cn1), msize[1]);
    chk("small.last_char", 32'(lc1), mlast[1]);
    chk("small.overflow",  32'(of1), 32'(movf[1]));
  endtask

  // One clock: drive inputs, advance model at the edge, check 1 time unit later.
  task automatic cyc(bit kv, int lc, bit rdy, bit r);
    key_valid   = kv;
    last_change = 9'(lc);
    out_ready   = rdy;
    rst         = r;
    @(posedge clk);
    model_step(0, kv, lc, rdy, r);
    model_step(1, kv, lc, rdy, r);
    #1;
    check_all();
  endtask

  task automatic key(int lc);
    cyc(1'b1, lc, 1'b1, 1'b0);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 0, 1'b1, 1'b0);
  endtask

  int pick;
  int rlc;

  initial begin
    // Reset
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("reset.count", 32'(cn0), 32'd0);
    chk("reset.busy",  32'(bz0), 32'd0);
    cyc(1'b0, 0, 1'b0, 1'b0);

    // A B C then enter, drains one per cycle
    key('h1C); key('h32); key('h21); key('h5A);
    chk("abc.first", 32'(od0), 32'd1);
    idle(1); chk("abc.second", 32'(od0), 32'd2);
    idle(1); chk("abc.third", 32'(od0), 32'd3);
    chk("abc.last", 32'(ol0), 32'd1);
    idle(1); chk("abc.done_busy", 32'(bz0), 32'd0);
    chk("abc.done_count", 32'(cn0), 32'd0);

    // Backspace editing
    key('h1C); key('h32); key('h66);
    chk("bksp.last_char", 32'(lc0), 32'd1);
    key('h21); key('h5A);
    chk("bksp.first", 32'(od0), 32'd1);
    idle(1); chk("bksp.second", 32'(od0), 32'd3);
    idle(1);
    key('h66); chk("bksp.empty", 32'(cn0), 32'd0);

    // Fill beyond the small instance's capacity
    key('h1C); key('h32); key('h21); key('h23);
    key('h24); chk("full.ovf", 32'(of1), 32'd1);
    chk("full.count", 32'(cn1), 32'd4);
    idle(1); chk("full.ovf_pulse", 32'(of1), 32'd0);
    key('h5A); idle(6);

    // Digits and E0-prefixed keys
    key('h16); chk("digit.big", 32'(lc0), 32'd29);
    chk("digit.small", 32'(cn1), 32'd0);
    key('h11C); chk("e0.ovf", 32'(of0), 32'd0);
    key('h66);

    // Stalled readout with a key arriving mid-line
    key('h1C); key('h32); key('h21);
    cyc(1'b1, 'h5A, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0); chk("stall.hold", 32'(od0), 32'd2);
    cyc(1'b1, 'h24, 1'b0, 1'b0); chk("stall.ovf", 32'(of0), 32'd1);
    chk("stall.hold2", 32'(od0), 32'd2);
    cyc(1'b0, 0, 1'b1, 1'b0);
    idle(2);

    // Reset mid-readout, then enter on the empty buffer
    key('h1C); key('h32); key('h5A); idle(1);
    cyc(1'b0, 0, 1'b1, 1'b1); chk("rst.busy", 32'(bz0), 32'd0);
    key('h5A); chk("rst.enter_empty", 32'(bz0), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      pick = $urandom_range(0, 11);
      if (pick <= 5)       rlc = sc_let[$urandom_range(0, 25)];
      else if (pick == 6)  rlc = sc_dig[$urandom_range(0, 9)];
      else if (pick == 7)  rlc = 'h29;
      else if (pick == 8)  rlc = 'h66;
      else if (pick == 9)  rlc = 'h5A;
      else                 rlc = $urandom_range(0, 511);
      cyc(($urandom_range(0, 2) != 0), rlc, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 299) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
